// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and defaults for the framebuffer SRAM arbiter: state encoding,
// SRAM geometry and default strobe timings.
package sram_access_arbiter_pkg;
  localparam int SRAM_ADDR_W      = 18;
  localparam int SRAM_DATA_W      = 16;
  localparam int DEF_RD_CYCLES    = 2;
  localparam int DEF_WR_CYCLES    = 2;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 3;
  localparam int CNT_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_TURN
  } arb_state_e;

  typedef struct packed {
    logic rd;
    logic wr;
  } arb_gnt_t;

  function automatic logic is_wr_state(arb_state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
  endfunction
endpackage

// File: rtl/sram_arb_grant.sv
// Read-priority grant with a bounded write-starvation guard; the counter only
// moves on cycles where the FSM actually takes a grant decision.
module sram_arb_grant
  import sram_access_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                sysClk,
  input  logic                reset,
  input  logic                decide,
  input  logic                rd_req,
  input  logic                wr_req,
  output arb_gnt_t            gnt,
  output logic [STARVE_W-1:0] starve_cnt
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  always_comb begin
    gnt = '0;
    if (decide) begin
      if (wr_req && (!rd_req || starve_cnt >= LIMIT)) gnt.wr = 1'b1;
      else if (rd_req)                                 gnt.rd = 1'b1;
    end
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset)                                          starve_cnt <= '0;
    else if (gnt.wr)                                    starve_cnt <= '0;
    else if (gnt.rd && wr_req && (starve_cnt != '1))    starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one async SRAM between the capture write port and the display read port.
// Every pin is registered from the next-state decode so strobes never glitch.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int RD_CYCLES    = DEF_RD_CYCLES,
  parameter int WR_CYCLES    = DEF_WR_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                sysClk,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ack,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [ADDR_W-1:0]   sram_addr,
  inout  wire  [DATA_W-1:0]   sram_data,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [STARVE_W-1:0] starve_cnt
);
  arb_state_e        state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic              rd_last, wr_last, decide;
  logic              start_rd, start_wr;
  logic              turn_to_wr, turn_to_wr_nxt;
  logic              drive_en;
  logic [DATA_W-1:0] wdata;
  arb_gnt_t          gnt;

  assign rd_last = (state == ST_RD)        && (cnt == CNT_W'(RD_CYCLES - 1));
  assign wr_last = (state == ST_WR_STROBE) && (cnt == CNT_W'(WR_CYCLES - 1));
  assign decide  = (state == ST_IDLE) || rd_last || (state == ST_WR_HOLD);

  sram_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .sysClk     (sysClk),
    .reset      (reset),
    .decide     (decide),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .gnt        (gnt),
    .starve_cnt (starve_cnt)
  );

  // A direction change parks in TURN; the granted direction is remembered so the
  // access can start straight after, unless its requester has since withdrawn.
  always_comb begin
    nxt            = state;
    start_rd       = 1'b0;
    start_wr       = 1'b0;
    turn_to_wr_nxt = turn_to_wr;
    unique case (state)
      ST_IDLE: begin
        if (gnt.rd)      begin nxt = ST_RD;       start_rd = 1'b1; end
        else if (gnt.wr) begin nxt = ST_WR_SETUP; start_wr = 1'b1; end
      end
      ST_RD: begin
        if (rd_last) begin
          if (gnt.rd)      begin nxt = ST_RD;   start_rd = 1'b1; end
          else if (gnt.wr) begin nxt = ST_TURN; turn_to_wr_nxt = 1'b1; end
          else             nxt = ST_IDLE;
        end
      end
      ST_WR_SETUP:  nxt = ST_WR_STROBE;
      ST_WR_STROBE: if (wr_last) nxt = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (gnt.wr)      begin nxt = ST_WR_SETUP; start_wr = 1'b1; end
        else if (gnt.rd) begin nxt = ST_TURN;     turn_to_wr_nxt = 1'b0; end
        else             nxt = ST_IDLE;
      end
      ST_TURN: begin
        if (turn_to_wr && wr_req)       begin nxt = ST_WR_SETUP; start_wr = 1'b1; end
        else if (!turn_to_wr && rd_req) begin nxt = ST_RD;       start_rd = 1'b1; end
        else                            nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      turn_to_wr <= 1'b0;
      sram_addr  <= '0;
      wdata      <= '0;
      drive_en   <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= nxt;
      turn_to_wr <= turn_to_wr_nxt;
      cnt        <= (start_rd || (nxt != state)) ? '0 : cnt + 1'b1;
      rd_ack     <= start_rd;
      wr_ack     <= start_wr;
      if (start_rd)      sram_addr <= rd_addr;
      else if (start_wr) sram_addr <= wr_addr;
      if (start_wr) wdata <= wr_data;
      sram_ce_n  <= !((nxt == ST_RD) || is_wr_state(nxt));
      sram_oe_n  <= (nxt != ST_RD);
      sram_we_n  <= (nxt != ST_WR_STROBE);
      drive_en   <= is_wr_state(nxt);
      rd_valid   <= rd_last;
      if (rd_last) rd_data <= sram_data;
    end
  end

  assign sram_data = drive_en ? wdata : {DATA_W{1'bz}};
endmodule
